// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller with shadow/active digit registers.
// Optional build macro SEG_LEADING_ZERO_BLANK_EN darkens leading-zero digits.
module seg_scan_ctrl #(
  parameter int DIGITS = 4,
  parameter int DIV    = 50000,
  parameter int DEAD   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  wr_en,
  input  logic [4*DIGITS-1:0]   wr_data,
  input  logic [DIGITS-1:0]     wr_dp,
  output logic [3:0]            hex_sel,
  input  logic [6:0]            display_in,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     digit_en,
  output logic                  frame_done,
  output logic                  pending
);

  localparam int TMAX = (DIV > DEAD) ? DIV : DEAD;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int IW   = $clog2(DIGITS);

  typedef enum logic [1:0] {S_IDLE, S_BLANK, S_SHOW} state_t;

  state_t                r_state;
  logic [TW-1:0]         r_tick;
  logic [IW-1:0]         r_idx;
  logic [4*DIGITS-1:0]   r_shadow;
  logic [DIGITS-1:0]     r_shadow_dp;
  logic [4*DIGITS-1:0]   r_active;
  logic [DIGITS-1:0]     r_active_dp;
  logic                  r_pending;
  logic [6:0]            r_seg;
  logic                  r_dp;
  logic [DIGITS-1:0]     r_digit_en;
  logic                  r_frame_done;

  logic                  w_blank_done;
  logic                  w_show_done;
  logic                  w_last_digit;
  logic                  w_swap;
  logic [3:0]            w_nibble;
  logic [DIGITS-1:0]     w_onehot;
  logic                  w_blank_digit;

  assign w_blank_done = (r_tick == TW'(DEAD - 1));
  assign w_show_done  = (r_tick == TW'(DIV - 1));
  assign w_last_digit = (r_idx == IW'(DIGITS - 1));
  assign w_nibble     = r_active[{r_idx, 2'b00} +: 4];
  assign w_onehot     = DIGITS'(1) << r_idx;

  // Swap happens on scan start and on the frame wrap edge, never when enable drops.
  assign w_swap = enable && r_pending &&
                  ((r_state == S_IDLE) ||
                   ((r_state == S_SHOW) && w_show_done && w_last_digit));

`ifdef SEG_LEADING_ZERO_BLANK_EN
  logic w_upper_zero;

  // A digit is a leading zero if it and every more significant nibble are zero.
  always_comb begin
    w_upper_zero = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      w_upper_zero = w_upper_zero &
                     ~((i >= int'(r_idx)) && (r_active[4*i +: 4] != 4'd0));
    end
    w_blank_digit = (r_idx != '0) && w_upper_zero && !r_active_dp[r_idx];
  end
`else
  assign w_blank_digit = 1'b0;
`endif

  // Shadow/active registers: the swap reads the old shadow, a coincident write refills it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shadow    <= '0;
      r_shadow_dp <= '0;
      r_active    <= '0;
      r_active_dp <= '0;
      r_pending   <= 1'b0;
    end else begin
      if (w_swap) begin
        r_active    <= r_shadow;
        r_active_dp <= r_shadow_dp;
      end
      if (wr_en) begin
        r_shadow    <= wr_data;
        r_shadow_dp <= wr_dp;
        r_pending   <= 1'b1;
      end else if (w_swap) begin
        r_pending   <= 1'b0;
      end
    end
  end

  // Scan FSM with registered segment, digit and frame outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_tick       <= '0;
      r_idx        <= '0;
      r_seg        <= 7'd0;
      r_dp         <= 1'b0;
      r_digit_en   <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (!enable) begin
        r_state    <= S_IDLE;
        r_tick     <= '0;
        r_idx      <= '0;
        r_seg      <= 7'd0;
        r_dp       <= 1'b0;
        r_digit_en <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_state <= S_BLANK;
            r_tick  <= '0;
            r_idx   <= '0;
          end
          S_BLANK: begin
            if (w_blank_done) begin
              r_state <= S_SHOW;
              r_tick  <= '0;
              r_dp    <= r_active_dp[r_idx];
              if (w_blank_digit) begin
                r_seg      <= 7'd0;
                r_digit_en <= '0;
              end else begin
                r_seg      <= display_in;
                r_digit_en <= w_onehot;
              end
            end else begin
              r_tick <= r_tick + TW'(1);
            end
          end
          S_SHOW: begin
            if (w_show_done) begin
              r_state    <= S_BLANK;
              r_tick     <= '0;
              r_seg      <= 7'd0;
              r_dp       <= 1'b0;
              r_digit_en <= '0;
              if (w_last_digit) begin
                r_idx        <= '0;
                r_frame_done <= 1'b1;
              end else begin
                r_idx <= r_idx + IW'(1);
              end
            end else begin
              r_tick <= r_tick + TW'(1);
            end
          end
          default: begin
            r_state    <= S_IDLE;
            r_tick     <= '0;
            r_idx      <= '0;
            r_seg      <= 7'd0;
            r_dp       <= 1'b0;
            r_digit_en <= '0;
          end
        endcase
      end
    end
  end

  assign hex_sel    = (r_state == S_IDLE) ? 4'd0 : w_nibble;
  assign seg        = r_seg;
  assign dp         = r_dp;
  assign digit_en   = r_digit_en;
  assign frame_done = r_frame_done;
  assign pending    = r_pending;

endmodule
